fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 16-bit single-cycle CPU. It owns the fetch PC (reset address 10) and issues requests to the instruction memory over a req/ack handshake. Returned instructions are buffered in a 2-entry prefetch queue and presented to the control unit / datapath with a valid/ready handshake. A branch/jump redirect from the datapath flushes the queue and restarts fetch.

## Interface
- RESET_PC, 16'd10, fetch address after reset
- ADDR_W, 16, address width
- INSTR_W, 16, instruction width
- DEPTH, 2, prefetch queue entries
- Clock  in  1  single clock, all state updates on posedge
- Reset_n  in  1  reset; synchronous, active-low
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address; stable while imem_req high and not acked
- imem_ack  in  1  one-cycle strobe, imem_rdata valid; may arrive in the same cycle as imem_req
- imem_rdata  in  INSTR_W  instruction word
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  queue head instruction
- instr_pc  out  ADDR_W  address of the queue-head instruction
- instr_ready  in  1  consumer takes head when instr_valid && instr_ready
- redirect  in  1  one-cycle strobe: discard all fetched or in-flight work
- redirect_pc  in  ADDR_W  new fetch address; bit 0 forced to 0

## Operation
- Byte addressing, 16-bit instructions: after each accepted fetch, fetch_pc <= fetch_pc + 2, wrapping 16'hFFFE -> 16'h0000.
- At most one outstanding memory request. Once imem_req is raised it stays high with a constant imem_addr until imem_ack; a request is never withdrawn.
- FSM states:
  - IDLE: reset state; imem_req=0; goes to FETCH on the first clock with Reset_n high.
  - FETCH: imem_req=1, imem_addr=fetch_pc. On ack, push {fetch_pc, imem_rdata} and advance fetch_pc. Go to FULL if the post-push/pop count == DEPTH, otherwise stay in FETCH.
  - FULL: imem_req=0. Return to FETCH when the count drops below DEPTH.
  - DISCARD: imem_req=1 with the old address. On ack, drop the data and go to FETCH at the redirected fetch_pc.
- Redirect (highest priority, overrides pop and push in that cycle):
  - Queue cleared; fetch_pc <= {redirect_pc[15:1],1'b0}.
  - In FETCH without ack in that cycle: go to DISCARD.
  - In FETCH with ack in the same cycle: data dropped; stay in FETCH.
  - In FULL or IDLE: go to FETCH.
  - In DISCARD: stay in DISCARD; the newest redirect_pc wins.
- Queue:
  - FIFO, DEPTH entries, count 0..DEPTH.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Pop when empty cannot occur, because instr_valid=0.
  - Outputs instr/instr_pc are zero when empty.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_pc=RESET_PC, count=0, state=IDLE.
- Reset asserted mid-operation returns to IDLE at the next edge. A late imem_ack during IDLE is ignored.
- First request appears 1 cycle after Reset_n rises.
- Latency is ack-edge -> instr_valid high at the next cycle. With zero-wait memory (ack same cycle as req), instr_valid is high 2 cycles after Reset_n rises.
- Sustained throughput is 1 instruction/cycle with zero-wait memory and instr_ready held high.
- instr_valid drops in the cycle after redirect. The first redirected instruction appears ≥1 cycle after its ack.
- imem_req is driven combinationally from registered state only; imem_ack does not feed imem_req combinationally.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum (IDLE, FETCH, FULL, DISCARD)
  - RESET_PC, ADDR_W, INSTR_W constants
  - the queue entry typedef {pc, instr}
- Sub-module `fetch_queue`: parameterised DEPTH-entry FIFO with push, pop, flush, count, and head outputs.
- `fetch_unit` holds the FSM and fetch_pc, and replaces the free-running PC register in the CPU top.

## Test plan
- Reset release, zero-wait memory, instr_ready=1 -> imem_addr sequence 10,12,14,16; instr_pc stream 10,12,14 with one instruction per cycle.
- instr_ready=0 for 6 cycles -> exactly 2 instructions (pc 10,12) are queued, imem_req drops (FULL), and imem_addr holds 14; ready=1 resumes 10,12,14 in order with none lost.
- 3-cycle-latency memory, redirect to 0x0040 one cycle after the req for 14 -> imem_req stays high at 14 until ack, the ack data is dropped, the next request is 0x0040, and the next instr_pc is 0x0040.
- Redirect in the same cycle as ack and pop, with 2 entries queued -> the queue is empty next cycle, no stale instr_pc is seen, and the next fetch is redirect_pc.
- redirect_pc=0x0031 -> fetch at 0x0030; fetch at 0xFFFE -> next address 0x0000.
- Reset_n low while in DISCARD with a pending ack -> state IDLE, all outputs at reset values, and the late ack is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: widths, reset
// address, FSM state encoding and the prefetch queue entry layout.
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'd10;

  // Fetch FSM states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // One prefetch queue entry: the instruction and the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO. Push and pop may happen together; flush empties
// it in one cycle. The head output reads as zero whenever the queue is empty.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Qualify requests so the FIFO can never over- or underflow on its own.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    count      = cnt;
    head_valid = (cnt != '0);
    head       = head_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one request at a time
// to instruction memory, buffers returned words in a small prefetch queue and
// handles branch/jump redirects by flushing and restarting fetch.
//
// Handshakes: imem_req/imem_addr are held constant until imem_ack (a request
// is never withdrawn; ack may arrive in the request's first cycle). On the
// consumer side an instruction transfers on a cycle with instr_valid &&
// instr_ready. redirect is a one-cycle strobe that overrides push and pop.
module fetch_unit #(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int                DEPTH    = fetch_pkg::DEPTH
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTR_W-1:0]           imem_rdata,
  output logic                         instr_valid,
  output logic [INSTR_W-1:0]           instr,
  output logic [ADDR_W-1:0]            instr_pc,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

  import fetch_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e       state;
  fetch_state_e       state_n;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  fetch_pc_n;
  logic [ADDR_W-1:0]  discard_addr;
  logic [ADDR_W-1:0]  discard_addr_n;

  logic               q_push;
  logic               q_pop;
  logic               q_flush;
  logic [CNT_W-1:0]   q_count;
  logic               q_valid;
  logic [ENTRY_W-1:0] q_head;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .flush      (q_flush),
    .push       (q_push),
    .push_data  ({fetch_pc, imem_rdata}),
    .pop        (q_pop),
    .count      (q_count),
    .head_valid (q_valid),
    .head       (q_head)
  );

  // State, fetch PC and the address of a request whose data will be dropped.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      state        <= state_n;
      fetch_pc     <= fetch_pc_n;
      discard_addr <= discard_addr_n;
    end
  end

  // Next-state, PC update and queue control; redirect wins over everything.
  always_comb begin
    state_n        = state;
    fetch_pc_n     = fetch_pc;
    discard_addr_n = discard_addr;
    q_push         = 1'b0;
    q_pop          = 1'b0;
    q_flush        = 1'b0;

    if (redirect) begin
      q_flush    = 1'b1;
      fetch_pc_n = {redirect_pc[ADDR_W-1:1], 1'b0};
      unique case (state)
        FETCH: begin
          // Unacked request must still complete at its old address.
          if (!imem_ack) begin
            state_n        = DISCARD;
            discard_addr_n = fetch_pc;
          end
        end
        DISCARD: state_n = DISCARD;
        default: state_n = FETCH;
      endcase
    end else begin
      q_pop = q_valid && instr_ready;
      unique case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (imem_ack) begin
            q_push     = 1'b1;
            fetch_pc_n = fetch_pc + ADDR_W'(2);
            if ((q_count + CNT_W'(1) - CNT_W'(q_pop)) == CNT_W'(DEPTH))
              state_n = FULL;
          end
        end
        FULL: begin
          if ((q_count - CNT_W'(q_pop)) < CNT_W'(DEPTH))
            state_n = FETCH;
        end
        DISCARD: begin
          if (imem_ack) state_n = FETCH;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs depend on registered state only, never on imem_ack.
  always_comb begin
    imem_req    = (state == FETCH) || (state == DISCARD);
    imem_addr   = (state == DISCARD) ? discard_addr : fetch_pc;
    instr_valid = q_valid;
    instr_pc    = q_head[ENTRY_W-1:INSTR_W];
    instr       = q_head[INSTR_W-1:0];
    dbg_state   = state;
    dbg_count   = q_count;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven cycle vectors, hand sequences for the
// multi-cycle corners, then randomized memory latency / ready / redirect
// against a stream model of the expected instruction sequence.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock
  always #5 Clock = ~Clock;

  fetch_unit dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [15:0] addr,
                            input logic v, input logic [15:0] pc, input logic [1:0] st);
    check({tag, " imem_req"}, 32'(imem_req), 32'(req));
    check({tag, " imem_addr"}, 32'(imem_addr), 32'(addr));
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(v));
    check({tag, " instr_pc"}, 32'(instr_pc), 32'(v ? pc : 16'h0));
    check({tag, " instr"}, 32'(instr), 32'(v ? mem_word(pc) : 16'h0));
    check({tag, " state"}, 32'(dbg_state), 32'(st));
  endtask

  // Driver: ack_mode 0 = no ack, 1 = ack if requesting, 2 = ack regardless.
  task automatic step(input int ack_mode, input logic rdy, input logic redir, input logic [15:0] rpc);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = (ack_mode == 2) || ((ack_mode == 1) && imem_req);
    imem_rdata  = mem_word(imem_addr);
    @(posedge Clock);
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        ack_en;
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [1:0]  e_state;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic rd, input logic rdr,
                              input logic [15:0] rpc, input logic er, input logic [15:0] ea,
                              input logic ev, input logic [15:0] ep, input logic [1:0] es);
    vec_t v;
    v.rst_n = r; v.ack_en = a; v.ready = rd; v.redir = rdr; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_state = es;
    return v;
  endfunction

  vec_t        vecs[22];
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [15:0] next_pc;
  logic [15:0] rpc;
  logic [15:0] prev_addr;
  logic        prev_pending;
  logic        prev_redir;
  logic        rdy;
  logic        redir;
  logic        ack;
  int          mem_wait;
  int          idle_run;
  int          max_idle;
  int          consumed;

  initial begin
    // Row fields: drive {rst_n, ack_en, ready, redirect, redirect_pc},
    // expected before driving {req, addr, valid, instr_pc, state}.
    vecs[0]  = mk(1, 1, 1, 0, 16'h0,    0, 16'd10,   0, 16'h0,    IDLE);
    vecs[1]  = mk(1, 1, 1, 0, 16'h0,    1, 16'd10,   0, 16'h0,    FETCH);
    vecs[2]  = mk(1, 1, 1, 0, 16'h0,    1, 16'd12,   1, 16'd10,   FETCH);
    vecs[3]  = mk(1, 1, 1, 0, 16'h0,    1, 16'd14,   1, 16'd12,   FETCH);
    vecs[4]  = mk(0, 0, 0, 0, 16'h0,    1, 16'd16,   1, 16'd14,   FETCH);
    vecs[5]  = mk(1, 1, 0, 0, 16'h0,    0, 16'd10,   0, 16'h0,    IDLE);
    vecs[6]  = mk(1, 1, 0, 0, 16'h0,    1, 16'd10,   0, 16'h0,    FETCH);
    vecs[7]  = mk(1, 1, 0, 0, 16'h0,    1, 16'd12,   1, 16'd10,   FETCH);
    vecs[8]  = mk(1, 1, 0, 0, 16'h0,    0, 16'd14,   1, 16'd10,   FULL);
    vecs[9]  = mk(1, 1, 0, 0, 16'h0,    0, 16'd14,   1, 16'd10,   FULL);
    vecs[10] = mk(1, 1, 0, 0, 16'h0,    0, 16'd14,   1, 16'd10,   FULL);
    vecs[11] = mk(1, 1, 1, 0, 16'h0,    0, 16'd14,   1, 16'd10,   FULL);
    vecs[12] = mk(1, 1, 1, 0, 16'h0,    1, 16'd14,   1, 16'd12,   FETCH);
    vecs[13] = mk(1, 1, 1, 0, 16'h0,    1, 16'd16,   1, 16'd14,   FETCH);
    vecs[14] = mk(1, 1, 1, 1, 16'h0031, 1, 16'd18,   1, 16'd16,   FETCH);
    vecs[15] = mk(1, 1, 1, 0, 16'h0,    1, 16'h0030, 0, 16'h0,    FETCH);
    vecs[16] = mk(1, 1, 1, 1, 16'hFFFE, 1, 16'h0032, 1, 16'h0030, FETCH);
    vecs[17] = mk(1, 1, 1, 0, 16'h0,    1, 16'hFFFE, 0, 16'h0,    FETCH);
    vecs[18] = mk(1, 0, 0, 1, 16'h0040, 1, 16'h0000, 1, 16'hFFFE, FETCH);
    vecs[19] = mk(1, 1, 1, 0, 16'h0,    1, 16'h0000, 0, 16'h0,    DISCARD);
    vecs[20] = mk(1, 1, 1, 0, 16'h0,    1, 16'h0040, 0, 16'h0,    FETCH);
    vecs[21] = mk(1, 1, 1, 0, 16'h0,    1, 16'h0042, 1, 16'h0040, FETCH);

    // Table phase
    do_reset();
    check("reset count", 32'(dbg_count), 32'd0);
    for (int i = 0; i < 22; i++) begin
      expect_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_state);
      Reset_n = vecs[i].rst_n;
      step(vecs[i].ack_en ? 1 : 0, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
    end

    // Redirect one cycle after the request for 14, memory answering 3 cycles late
    do_reset();
    Reset_n = 1'b1;
    step(0, 1, 0, 16'h0);
    expect_out("lat c1", 1, 16'd10, 0, 16'h0, FETCH);
    step(1, 1, 0, 16'h0);
    expect_out("lat c2", 1, 16'd12, 1, 16'd10, FETCH);
    step(1, 1, 0, 16'h0);
    expect_out("lat c3", 1, 16'd14, 1, 16'd12, FETCH);
    step(0, 1, 0, 16'h0);
    expect_out("lat c4", 1, 16'd14, 0, 16'h0, FETCH);
    step(0, 1, 1, 16'h0040);
    expect_out("lat c5", 1, 16'd14, 0, 16'h0, DISCARD);
    step(0, 1, 0, 16'h0);
    expect_out("lat c6", 1, 16'd14, 0, 16'h0, DISCARD);
    step(1, 1, 0, 16'h0);
    expect_out("lat c7", 1, 16'h0040, 0, 16'h0, FETCH);
    step(1, 0, 0, 16'h0);
    expect_out("lat c8", 1, 16'h0042, 1, 16'h0040, FETCH);

    // Redirect together with a pop while the queue holds two entries
    do_reset();
    Reset_n = 1'b1;
    step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    expect_out("full c3", 0, 16'd14, 1, 16'd10, FULL);
    check("full c3 count", 32'(dbg_count), 32'd2);
    step(1, 1, 1, 16'h0200);
    expect_out("flush c4", 1, 16'h0200, 0, 16'h0, FETCH);
    check("flush c4 count", 32'(dbg_count), 32'd0);
    step(1, 1, 0, 16'h0);
    expect_out("flush c5", 1, 16'h0202, 1, 16'h0200, FETCH);

    // Reset while discarding with the ack arriving, then a stray ack in IDLE
    do_reset();
    Reset_n = 1'b1;
    step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0100);
    expect_out("rst c2", 1, 16'd10, 0, 16'h0, DISCARD);
    Reset_n = 1'b0;
    step(1, 1, 0, 16'h0);
    expect_out("rst c3", 0, 16'd10, 0, 16'h0, IDLE);
    check("rst c3 count", 32'(dbg_count), 32'd0);
    Reset_n = 1'b1;
    step(2, 1, 0, 16'h0);
    expect_out("rst c4", 1, 16'd10, 0, 16'h0, FETCH);
    check("rst c4 count", 32'(dbg_count), 32'd0);

    // Randomized phase: expected stream is a contiguous run from the last target
    do_reset();
    Reset_n = 1'b1;
    step(0, 0, 0, 16'h0);
    exp_q.delete();
    next_pc = RESET_PC;
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 16'd2;
    end
    mem_wait     = -1;
    prev_pending = 1'b0;
    prev_redir   = 1'b0;
    prev_addr    = '0;
    idle_run     = 0;
    max_idle     = 0;
    consumed     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_pending) begin
        check("rnd req held", 32'(imem_req), 32'd1);
        check("rnd addr held", 32'(imem_addr), 32'(prev_addr));
      end
      if (prev_redir) check("rnd valid after redirect", 32'(instr_valid), 32'd0);
      if (!instr_valid && !imem_req) idle_run++;
      else idle_run = 0;
      if (idle_run > max_idle) max_idle = idle_run;

      redir = ($urandom_range(0, 19) == 0);
      rdy   = redir ? 1'b0 : ($urandom_range(0, 3) != 0);
      ack   = 1'b0;
      if (imem_req) begin
        if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
        if (mem_wait == 0) begin
          ack      = 1'b1;
          mem_wait = -1;
        end else begin
          mem_wait--;
        end
      end else begin
        mem_wait = -1;
      end

      if (instr_valid && rdy && !redir) begin
        e = exp_q.pop_front();
        check("rnd instr_pc", 32'(instr_pc), 32'(e[31:16]));
        check("rnd instr", 32'(instr), 32'(e[15:0]));
        consumed++;
      end
      rpc = '0;
      if (redir) begin
        rpc = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) rpc = 16'hFFF0 | {12'h0, rpc[3:0]};
        exp_q.delete();
        next_pc = {rpc[15:1], 1'b0};
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back({next_pc, mem_word(next_pc)});
        next_pc = next_pc + 16'd2;
      end

      prev_pending = imem_req && !ack;
      prev_addr    = imem_addr;
      prev_redir   = redir;
      step(ack ? 2 : 0, rdy, redir, rpc);
    end
    check("rnd longest idle run", 32'(max_idle), 32'd0);
    check("rnd enough consumed", 32'(consumed > 300), 32'd1);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
